// File: rtl/ibex_mem_arbiter.sv
// Arbitrates Ibex instruction and data OBI requests onto one single-port RAM (1-cycle read latency).
// Define MEM_ARB_STARVE_GUARD_EN to let a starved data request override instruction priority.
module ibex_mem_arbiter #(
  parameter int unsigned MEM_SIZE     = 8192,
  parameter logic [31:0] MEM_START    = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] WIN_MASK = ~(MEM_SIZE - 32'd1);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_INSTR_OK,
    OWN_INSTR_ERR,
    OWN_DATA_OK,
    OWN_DATA_ERR
  } owner_e;

  function automatic logic in_window(input logic [31:0] addr);
    return (addr & WIN_MASK) == MEM_START;
  endfunction

  logic        data_override;
  logic        sel_instr, sel_data;
  logic [31:0] win_addr;
  logic        win_ok;
  logic        mem_go;
  owner_e      owner_q, owner_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign data_override = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts cycles a waiting data request has lost; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!data_req_i || data_gnt_o) begin
      starve_d = '0;
    end else if (!data_override) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign data_override = 1'b0;
`endif

  // Grant stage: pick one winner; nothing is granted while reset is held.
  always_comb begin
    sel_instr = 1'b0;
    sel_data  = 1'b0;
    if (rst_sys_n) begin
      if (data_req_i && data_override) begin
        sel_data = 1'b1;
      end else if (instr_req_i) begin
        sel_instr = 1'b1;
      end else if (data_req_i) begin
        sel_data = 1'b1;
      end
    end
  end

  assign win_addr = sel_data ? data_addr_i : instr_addr_i;
  assign win_ok   = in_window(win_addr);
  assign mem_go   = (sel_instr | sel_data) & win_ok;

  assign instr_gnt_o = sel_instr;
  assign data_gnt_o  = sel_data;

  assign mem_req_o   = mem_go;
  assign mem_we_o    = mem_go & sel_data & data_we_i;
  assign mem_be_o    = !mem_go ? 4'h0 : (sel_data ? data_be_i : 4'hF);
  assign mem_addr_o  = mem_go ? win_addr : 32'h0;
  assign mem_wdata_o = (mem_go && sel_data) ? data_wdata_i : 32'h0;

  always_comb begin
    owner_d = OWN_NONE;
    if (sel_instr) begin
      owner_d = win_ok ? OWN_INSTR_OK : OWN_INSTR_ERR;
    end else if (sel_data) begin
      owner_d = win_ok ? OWN_DATA_OK : OWN_DATA_ERR;
    end
  end

  // Response stage: the owner register steers the RAM read data one cycle after grant.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign instr_rvalid_o = (owner_q == OWN_INSTR_OK) || (owner_q == OWN_INSTR_ERR);
  assign instr_err_o    = (owner_q == OWN_INSTR_ERR);
  assign instr_rdata_o  = (owner_q == OWN_INSTR_OK) ? mem_rdata_i : 32'h0;

  assign data_rvalid_o  = (owner_q == OWN_DATA_OK) || (owner_q == OWN_DATA_ERR);
  assign data_err_o     = (owner_q == OWN_DATA_ERR);
  assign data_rdata_o   = (owner_q == OWN_DATA_OK) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter: directed steps then random traffic against a reference model.
module tb_ibex_mem_arbiter;

  localparam int unsigned MEM_SIZE  = 8192;
  localparam int unsigned MEM_START = 0;
  localparam int          WORDS     = MEM_SIZE / 4;
  localparam int          LIMIT     = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  always #5 clk_sys = ~clk_sys;

  ibex_mem_arbiter #(
    .MEM_SIZE(MEM_SIZE), .MEM_START(32'(MEM_START)), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // RAM attached to the arbiter: filled on the first edge, then 1-cycle read latency.
  logic [31:0] ram [WORDS];
  logic        ram_ready = 1'b0;
  always @(posedge clk_sys) begin
    if (!ram_ready) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_req_o) begin
      mem_rdata_i <= ram[mem_addr_o[12:2]];
      if (mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [WORDS];
  int          lost;
  bit          pend_i, pend_d, pend_err, pend_store;
  logic [31:0] pend_rdata;
  int          checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'(MEM_START)) && ((a - 32'(MEM_START)) < 32'(MEM_SIZE));
  endfunction

  task automatic cycle(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwd);
    bit          win_i, win_d, hit;
    logic [31:0] waddr;
    int          idx;
    instr_req_i = ireq; instr_addr_i = iaddr;
    data_req_i = dreq; data_we_i = dwe; data_be_i = dbe; data_addr_i = daddr; data_wdata_i = dwd;
    #2;
    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(pend_i));
    chk("data_rvalid", 32'(data_rvalid_o), 32'(pend_d));
    chk("instr_err", 32'(instr_err_o), 32'(pend_i & pend_err));
    chk("data_err", 32'(data_err_o), 32'(pend_d & pend_err));
    chk("instr_rdata", instr_rdata_o, pend_i ? pend_rdata : 32'h0);
    if (!(pend_d && pend_store)) chk("data_rdata", data_rdata_o, pend_d ? pend_rdata : 32'h0);
    chk("dual_rvalid", 32'(instr_rvalid_o & data_rvalid_o), 32'h0);
    win_d = dreq && ((GUARD && lost >= LIMIT) || !ireq);
    win_i = ireq && !win_d;
    waddr = win_d ? daddr : iaddr;
    hit   = (win_i || win_d) && in_win(waddr);
    chk("instr_gnt", 32'(instr_gnt_o), 32'(win_i));
    chk("data_gnt", 32'(data_gnt_o), 32'(win_d));
    chk("mem_req", 32'(mem_req_o), 32'(hit));
    chk("mem_addr", mem_addr_o, hit ? waddr : 32'h0);
    chk("mem_we", 32'(mem_we_o), 32'(hit && win_d && dwe));
    chk("mem_be", 32'(mem_be_o), !hit ? 32'h0 : (win_d ? 32'(dbe) : 32'hF));
    chk("mem_wdata", mem_wdata_o, (hit && win_d) ? dwd : 32'h0);
    idx        = int'((waddr - 32'(MEM_START)) / 4);
    pend_i     = win_i;
    pend_d     = win_d;
    pend_err   = (win_i || win_d) && !hit;
    pend_store = win_d && dwe;
    pend_rdata = hit ? ref_mem[idx] : 32'h0;
    if (hit && win_d && dwe)
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
    lost = (dreq && !win_d) ? ((lost + 1 > LIMIT) ? LIMIT : lost + 1) : 0;
    @(posedge clk_sys); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ignt"}, 32'(instr_gnt_o), 32'h0);
    chk({tag, "_dgnt"}, 32'(data_gnt_o), 32'h0);
    chk({tag, "_mreq"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_maddr"}, mem_addr_o, 32'h0);
    chk({tag, "_mbe"}, 32'(mem_be_o), 32'h0);
    chk({tag, "_irv"}, 32'(instr_rvalid_o), 32'h0);
    chk({tag, "_drv"}, 32'(data_rvalid_o), 32'h0);
    chk({tag, "_irdata"}, instr_rdata_o, 32'h0);
    chk({tag, "_drdata"}, data_rdata_o, 32'h0);
    chk({tag, "_derr"}, 32'(data_err_o), 32'h0);
  endtask

  logic [31:0] ra, rb;
  initial begin
    checks = 0; failures = 0; lost = 0;
    pend_i = 0; pend_d = 0; pend_err = 0; pend_store = 0; pend_rdata = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    rst_sys_n = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h100; data_wdata_i = 32'h1234_5678;
    repeat (2) @(posedge clk_sys);
    #1;
    chk_all_zero("reset");
    instr_req_i = 1'b0; data_req_i = 1'b0;
    rst_sys_n = 1'b1;
    @(posedge clk_sys); #1;

    // Lone fetch, then idle to see its response.
    cycle(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Partial store then load of the same word.
    cycle(0, 32'h0, 1, 1, 4'h3, 32'h100, 32'hDEAD_BEEF);
    cycle(0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
    #1;
    chk("load_merge", data_rdata_o, (init_word(64) & 32'hFFFF_0000) | 32'h0000_BEEF);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Both requesting with instr held high: starvation behaviour.
    for (int k = 0; k < 10; k++) cycle(1, 32'h200 + 32'(4 * k), 1, 0, 4'hF, 32'h300, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Out-of-range data load, then out-of-range fetch.
    cycle(0, 32'h0, 1, 0, 4'hF, 32'h0001_0000, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(1, 32'hFFFF_FFF0, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Alternating single-port requests, back to back.
    for (int k = 0; k < 8; k++)
      if (k % 2 == 0) cycle(1, 32'h400 + 32'(4 * k), 0, 0, 4'h0, 32'h0, 32'h0);
      else            cycle(0, 32'h0, 1, 0, 4'hF, 32'h800 + 32'(4 * k), 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Reset asserted in the cycle after a grant drops the pending response.
    cycle(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0);
    instr_req_i = 1'b1; data_req_i = 1'b1;
    rst_sys_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    pend_i = 0; pend_d = 0; pend_err = 0; lost = 0;
    @(posedge clk_sys); #1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    rst_sys_n = 1'b1;
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h0001_0000) : 32'($urandom_range(0, MEM_SIZE - 1));
      rb = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h0002_0000) : 32'($urandom_range(0, MEM_SIZE - 1));
      cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), rb, $urandom());
    end
    cycle(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
Name: ibex_mem_arbiter

Overview:
Arbitrates the Ibex instruction and data OBI-style request ports onto one shared single-port RAM with 1-cycle read latency. Issues at most one grant per cycle and routes the RAM response back to the owning port. Decodes the RAM window and returns an error response for out-of-range accesses without touching the RAM. Sits between ibex_core and the RAM in the non-secure memory configuration.

Parameters:
MEM_SIZE, 8192, RAM size in bytes; power of two.
MEM_START, 32'h00000000, RAM base address; aligned to MEM_SIZE.
STARVE_LIMIT, 4, consecutive lost cycles after which a pending data request overrides instruction priority; must be >= 1.

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  reset
instr_req_i  in  1  instruction fetch request
instr_addr_i  in  32  fetch byte address
instr_gnt_o  out  1  fetch granted (combinational, same cycle)
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch data
instr_err_o  out  1  fetch out of range (qualified by rvalid)
data_req_i  in  1  data request
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_addr_i  in  32  data byte address
data_wdata_i  in  32  store data
data_gnt_o  out  1  data granted (combinational, same cycle)
data_rvalid_o  out  1  data response valid (loads and stores)
data_rdata_o  out  32  load data
data_err_o  out  1  data out of range (qualified by rvalid)
mem_req_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_addr_o  out  32  RAM byte address
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data, valid cycle after mem_req_o

Behaviour:
- Reset: rst_sys_n, asynchronous, active-low; clock clk_sys.
- Reset values: all gnt/mem_* outputs 0 while rst_sys_n low; rvalid_o = 0, err_o = 0, rdata_o = 0; owner = NONE; starve counter = 0.
- In-range: (addr & ~(MEM_SIZE-1)) == MEM_START.
- Selection each cycle: winner = data if data_req_i and starve counter == STARVE_LIMIT; else instr if instr_req_i; else data if data_req_i; else none.
- Winner's gnt_o = 1 in the same cycle; loser's gnt_o = 0, loser keeps req asserted.
- Winner in-range: mem_req_o = 1, mem_* driven from winner (instr: we = 0, be = 4'hF, wdata = 0). Out-of-range: mem_req_o = 0, grant still issued.
- mem_* = 0 when no winner or when winner is out of range.
- Owner register: states NONE, INSTR_OK, INSTR_ERR, DATA_OK, DATA_ERR, loaded every cycle from the current winner/range (NONE if no grant).
- Response, exactly 1 cycle after grant: owner's rvalid_o = 1. *_OK: rdata_o = mem_rdata_i, err_o = 0. *_ERR: rdata_o = 0, err_o = 1. The non-owner port sees rvalid = 0 and rdata = 0.
- Stores also get rvalid; data_rdata_o is don't-care for stores.
- Back-to-back: a new grant is allowed in the same cycle as the previous response. Throughput is 1 access per cycle.
- Starve counter: increments (saturating at STARVE_LIMIT) when data_req_i = 1 and data_gnt_o = 0; clears on data grant or when data_req_i = 0.
- Reset mid-operation: a pending response is dropped, and no rvalid is issued after reset deassertion until a new grant.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined: starve counter and override active as above.
- Undefined: no counter; strict instruction priority. Data is granted only when instr_req_i = 0.

Test Plan:
- Instr fetch 0x80 alone -> instr_gnt same cycle, mem_addr = 0x80, mem_we = 0; next cycle instr_rvalid = 1, instr_rdata = RAM[0x80], err = 0.
- Data store 0x100, be = 4'h3, wdata = 0xDEADBEEF, then load 0x100 -> RAM word = 0x????BEEF; load rvalid with that data, one cycle after its grant.
- Both requesting, guard enabled, STARVE_LIMIT = 4, instr held high -> instr granted cycles 0-3, data granted cycle 4, counter back to 0; with guard disabled, data never granted while instr_req high.
- Data load at 0x0001_0000 -> data_gnt, mem_req = 0; next cycle data_rvalid = 1, data_err = 1, data_rdata = 0; instr port unaffected.
- Alternating instr/data grants every cycle -> each rvalid routed to the correct port; no rvalid on both ports in the same cycle.
- Assert rst_sys_n low in the cycle after a grant -> no rvalid after release; all outputs 0 during reset.
